// File: rtl/foreign_bytequeue.sv
// Byte-granular instruction fetch queue: 16-byte packets in, variable-length
// instructions retired from the head, with a registered 16-byte decode window.
module foreign_bytequeue #(
  parameter int QBYTES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fetch_en,
  input  logic [127:0] fetch_data,
  output logic         fetch_rdy,
  input  logic         flush,
  input  logic         consume_en,
  input  logic [4:0]   consume_len,
  output logic [64:0]  A,
  output logic [64:0]  B,
  output logic         dataEn,
  output logic [5:0]   count,
  output logic         len_err
);

  logic [7:0]  q_q [QBYTES];
  logic [7:0]  q_d [QBYTES];
  logic [7:0]  shifted [QBYTES];
  logic [5:0]  count_q, count_d;
  logic        len_err_q, len_err_d;
  logic [64:0] a_q, a_d;
  logic [64:0] b_q, b_d;
  logic        data_en_q, data_en_d;
  logic        legal;
  logic        accept;
  logic [5:0]  len_l;
  logic [5:0]  base;

  assign fetch_rdy = (count_q <= 6'd16);

  always_comb begin
    accept = fetch_en && fetch_rdy;
    legal  = consume_en && (consume_len != 5'd0) && (consume_len <= 5'd15) &&
             ({1'b0, consume_len} <= count_q);
    len_l  = legal ? {1'b0, consume_len} : 6'd0;
    base   = count_q - len_l;

    // Shift out the retired bytes first, then append the packet behind the survivors.
    for (int i = 0; i < QBYTES; i++) begin
      shifted[i] = 8'h00;
      if (i + int'(len_l) < QBYTES) begin
        shifted[i] = q_q[5'(i + int'(len_l))];
      end
    end
    q_d = shifted;
    if (accept) begin
      for (int k = 0; k < 16; k++) begin
        q_d[5'(int'(base) + k)] = fetch_data[k*8 +: 8];
      end
    end

    count_d   = base + (accept ? 6'd16 : 6'd0);
    len_err_d = len_err_q | (consume_en & ~legal);

    if (flush) begin
      q_d       = q_q;
      count_d   = 6'd0;
      len_err_d = 1'b0;
    end

    // Window is built from the next state so it lines up with the new count.
    a_d = '0;
    b_d = '0;
    for (int i = 0; i < 8; i++) begin
      a_d[i*8 +: 8] = (6'(i) < count_d) ? q_d[i] : 8'h00;
      b_d[i*8 +: 8] = (6'(i + 8) < count_d) ? q_d[i + 8] : 8'h00;
    end
    a_d[64]   = (count_d >= 6'd8);
    b_d[64]   = (count_d >= 6'd16);
    data_en_d = (count_d >= 6'd16);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QBYTES; i++) begin
        q_q[i] <= 8'h00;
      end
      count_q   <= 6'd0;
      len_err_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      data_en_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      count_q   <= count_d;
      len_err_q <= len_err_d;
      a_q       <= a_d;
      b_q       <= b_d;
      data_en_q <= data_en_d;
    end
  end

  assign A       = a_q;
  assign B       = b_q;
  assign dataEn  = data_en_q;
  assign count   = count_q;
  assign len_err = len_err_q;

endmodule
